unidad_control_multiciclo: RTL and testbench
============================================

// Module: unidad_control_multiciclo
// PURPOSE
//  Multi-cycle successor to the single-cycle control decoder: FSM sequencing FETCH/DECODE/EXEC/MEM/WB per
//  RV32I instruction over one shared memory port with a ready handshake. Sits between the IR opcode field,
//  the ALU zero flag and the datapath muxes/enables. Adds I-type ALU, optional JAL, illegal-opcode trap,
//  memory-wait timeout and a retired-instruction counter.
// PARAMETERS
//  MAX_ESPERA  16  max cycles waiting on mem_listo in FETCH/MEM before timeout trap (>=2)
//  CNT_W       32  width of contador_instr
//  HAB_JAL     1   1: JAL (1101111) legal; 0: JAL is illegal opcode
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      synchronous, active-high reset
//  opcode          in   7      IR[6:0], sampled in DECODE
//  mem_listo       in   1      memory completes current access this cycle
//  zero            in   1      ALU zero flag (branch resolve in EXEC)
//  estado          out  3      FSM state: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//  alu_op          out  2      00 add, 01 sub/compare, 10 funct-decoded
//  alu_fuente      out  1      0 rs2, 1 immediate
//  mem_lectura     out  1      memory read request
//  mem_escritura   out  1      memory write request
//  iord            out  1      memory address: 0 PC, 1 ALU result
//  ir_escritura    out  1      load IR from memory data
//  pc_escritura    out  1      PC register enable
//  pc_fuente       out  2      00 PC+4, 01 branch target, 10 jump target
//  reg_escritura   out  1      register file write enable
//  mem_a_reg       out  2      writeback source: 00 ALU, 01 memory data, 10 PC+4
//  trampa          out  1      sticky trap flag, held in TRAP
//  causa_trampa    out  1      0 illegal opcode, 1 memory timeout (valid while trampa=1)
//  contador_instr  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Registers: estado, opcode_r[6:0], espera counter (clog2(MAX_ESPERA) bits), contador_instr, causa_trampa.
//  - Outputs decoded combinationally from estado, opcode_r, mem_listo, zero; any output not listed is 0.
//  - rst=1 at edge: estado<=FETCH, opcode_r<=0, espera<=0, contador_instr<=0, causa_trampa<=0. Thus after
//    reset: mem_lectura=1, all other control outputs 0, trampa=0. rst overrides every state incl. TRAP.
//  - FETCH: mem_lectura=1, iord=0. mem_listo=1: ir_escritura=1, pc_escritura=1, pc_fuente=00, ->DECODE.
//    Else espera++; when espera==MAX_ESPERA-1 and mem_listo=0 -> TRAP, causa=1. espera cleared on leaving.
//  - DECODE: opcode_r<=opcode. Legal: 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BR,
//    1101111 JAL (if HAB_JAL) -> EXEC; else -> TRAP, causa=0. Outputs all 0.
//  - EXEC: R: alu_op=10, alu_fuente=0 ->WB. I-ALU: alu_op=10, alu_fuente=1 ->WB. LW/SW: alu_op=00,
//    alu_fuente=1 ->MEM. BR: alu_op=01, pc_fuente=01, pc_escritura=zero ->FETCH, retires.
//    JAL: pc_fuente=10, pc_escritura=1, reg_escritura=1, mem_a_reg=10 ->FETCH, retires.
//  - MEM: iord=1, alu_op=00, alu_fuente=1; LW mem_lectura=1, SW mem_escritura=1. mem_listo=1: LW->WB,
//    SW->FETCH (retires). Timeout rule identical to FETCH (causa=1).
//  - WB: reg_escritura=1; mem_a_reg=01 for LW else 00 -> FETCH, retires.
//  - Retire = the transition into FETCH from EXEC/MEM/WB: contador_instr+1 that edge; wraps all-ones->0.
//  - TRAP: trampa=1, all other controls 0, no memory request; stays until rst. Counter frozen.
//  - mem_listo outside FETCH/MEM ignored. mem_listo same cycle as timeout threshold: access completes, no trap.
//  - Unused estado codes 6,7: next state TRAP, causa=0.
// TESTING
//  1 rst, R-type 0110011, mem_listo=1 every access -> estado 0,1,2,4,0; reg_escritura=1 in WB; count=1.
//  2 LW with mem_listo 3 cycles late in MEM -> MEM held 4 cycles, mem_lectura=1 held, WB mem_a_reg=01.
//  3 BEQ zero=1 then zero=0 -> EXEC pc_escritura=1 pc_fuente=01 first, 0 second; each 3 cycles, count+1.
//  4 opcode 7'b1111111 -> DECODE->TRAP, trampa=1 causa=0 held 20 cycles; rst -> FETCH, count=0.
//  5 mem_listo stuck 0, MAX_ESPERA=16 -> TRAP after 16 FETCH cycles, causa=1; listo on 16th cycle -> no trap.
//  6 HAB_JAL=0: JAL -> TRAP; HAB_JAL=1: JAL -> pc_fuente=10, mem_a_reg=10; CNT_W=4 after 16 instrs -> 0.

Source files
------------

// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a shared
// memory port, with illegal-opcode and memory-timeout traps plus a retired-instruction counter.
module unidad_control_multiciclo #(
  parameter int unsigned MAX_ESPERA = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned HAB_JAL    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_listo,
  input  logic             zero,
  output logic [2:0]       estado,
  output logic [1:0]       alu_op,
  output logic             alu_fuente,
  output logic             mem_lectura,
  output logic             mem_escritura,
  output logic             iord,
  output logic             ir_escritura,
  output logic             pc_escritura,
  output logic [1:0]       pc_fuente,
  output logic             reg_escritura,
  output logic [1:0]       mem_a_reg,
  output logic             trampa,
  output logic             causa_trampa,
  output logic [CNT_W-1:0] contador_instr
);

  localparam int unsigned ESP_W = $clog2(MAX_ESPERA);
  localparam logic [ESP_W-1:0] ESP_TOUT = ESP_W'(MAX_ESPERA - 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } estado_t;

  estado_t          r_estado;
  logic [6:0]       r_opcode;
  logic [ESP_W-1:0] r_espera;
  logic [CNT_W-1:0] r_cnt;
  logic             r_causa;
  logic             w_legal;
  logic             w_jal_ok;

  assign w_jal_ok = (HAB_JAL != 0);
  assign w_legal  = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW) ||
                    (opcode == OP_SW) || (opcode == OP_BR) ||
                    (w_jal_ok && (opcode == OP_JAL));

  // State, latched opcode, wait counter, retire counter and trap cause
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= S_FETCH;
      r_opcode <= '0;
      r_espera <= '0;
      r_cnt    <= '0;
      r_causa  <= 1'b0;
    end else begin
      case (r_estado)
        S_FETCH: begin
          if (mem_listo) begin
            r_estado <= S_DECODE;
            r_espera <= '0;
          end else if (r_espera == ESP_TOUT) begin
            r_estado <= S_TRAP;
            r_causa  <= 1'b1;
            r_espera <= '0;
          end else begin
            r_espera <= r_espera + ESP_W'(1);
          end
        end
        S_DECODE: begin
          r_opcode <= opcode;
          if (w_legal) begin
            r_estado <= S_EXEC;
          end else begin
            r_estado <= S_TRAP;
            r_causa  <= 1'b0;
          end
        end
        S_EXEC: begin
          if ((r_opcode == OP_R) || (r_opcode == OP_I)) begin
            r_estado <= S_WB;
          end else if ((r_opcode == OP_LW) || (r_opcode == OP_SW)) begin
            r_estado <= S_MEM;
          end else if ((r_opcode == OP_BR) || (w_jal_ok && (r_opcode == OP_JAL))) begin
            r_estado <= S_FETCH;
            r_cnt    <= r_cnt + CNT_W'(1);
          end else begin
            r_estado <= S_TRAP;
            r_causa  <= 1'b0;
          end
        end
        S_MEM: begin
          if (mem_listo) begin
            r_espera <= '0;
            if (r_opcode == OP_LW) begin
              r_estado <= S_WB;
            end else begin
              r_estado <= S_FETCH;
              r_cnt    <= r_cnt + CNT_W'(1);
            end
          end else if (r_espera == ESP_TOUT) begin
            r_estado <= S_TRAP;
            r_causa  <= 1'b1;
            r_espera <= '0;
          end else begin
            r_espera <= r_espera + ESP_W'(1);
          end
        end
        S_WB: begin
          r_estado <= S_FETCH;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_TRAP: begin
          r_estado <= S_TRAP;
        end
        default: begin
          r_estado <= S_TRAP;
          r_causa  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state and same-cycle handshakes
  always_comb begin
    alu_op        = 2'b00;
    alu_fuente    = 1'b0;
    mem_lectura   = 1'b0;
    mem_escritura = 1'b0;
    iord          = 1'b0;
    ir_escritura  = 1'b0;
    pc_escritura  = 1'b0;
    pc_fuente     = 2'b00;
    reg_escritura = 1'b0;
    mem_a_reg     = 2'b00;
    trampa        = 1'b0;
    case (r_estado)
      S_FETCH: begin
        mem_lectura  = 1'b1;
        ir_escritura = mem_listo;
        pc_escritura = mem_listo;
      end
      S_EXEC: begin
        if ((r_opcode == OP_R) || (r_opcode == OP_I)) begin
          alu_op     = 2'b10;
          alu_fuente = (r_opcode == OP_I);
        end else if ((r_opcode == OP_LW) || (r_opcode == OP_SW)) begin
          alu_fuente = 1'b1;
        end else if (r_opcode == OP_BR) begin
          alu_op       = 2'b01;
          pc_fuente    = 2'b01;
          pc_escritura = zero;
        end else if (w_jal_ok && (r_opcode == OP_JAL)) begin
          pc_fuente     = 2'b10;
          pc_escritura  = 1'b1;
          reg_escritura = 1'b1;
          mem_a_reg     = 2'b10;
        end
      end
      S_MEM: begin
        iord          = 1'b1;
        alu_fuente    = 1'b1;
        mem_lectura   = (r_opcode == OP_LW);
        mem_escritura = (r_opcode == OP_SW);
      end
      S_WB: begin
        reg_escritura = 1'b1;
        mem_a_reg     = (r_opcode == OP_LW) ? 2'b01 : 2'b00;
      end
      S_TRAP: begin
        trampa = 1'b1;
      end
      default: begin
        trampa = 1'b0;
      end
    endcase
  end

  assign estado         = 3'(r_estado);
  assign causa_trampa   = r_causa;
  assign contador_instr = r_cnt;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Scoreboard bench: instruction-level generator predicts every cycle's outputs for two
// configurations (defaults; and MAX_ESPERA=4, CNT_W=4, HAB_JAL=0), monitor compares at negedge.
module tb_unidad_control_multiciclo;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [2:0]  estado;
    logic [1:0]  alu_op;
    logic        alu_fuente;
    logic        mem_lectura;
    logic        mem_escritura;
    logic        iord;
    logic        ir_escritura;
    logic        pc_escritura;
    logic [1:0]  pc_fuente;
    logic        reg_escritura;
    logic [1:0]  mem_a_reg;
    logic        trampa;
    logic        causa;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    int    dut;
    obs_t  o;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, mem_listo_a = 1'b0, zero_a = 1'b0;
  logic [6:0] opcode_a = 7'd0;
  logic [2:0] estado_a;
  logic [1:0] alu_op_a, pc_fuente_a, mem_a_reg_a;
  logic       alu_fuente_a, mem_lectura_a, mem_escritura_a, iord_a, ir_escritura_a;
  logic       pc_escritura_a, reg_escritura_a, trampa_a, causa_a;
  logic [31:0] cnt_a;

  logic       rst_b = 1'b1, mem_listo_b = 1'b0, zero_b = 1'b0;
  logic [6:0] opcode_b = 7'd0;
  logic [2:0] estado_b;
  logic [1:0] alu_op_b, pc_fuente_b, mem_a_reg_b;
  logic       alu_fuente_b, mem_lectura_b, mem_escritura_b, iord_b, ir_escritura_b;
  logic       pc_escritura_b, reg_escritura_b, trampa_b, causa_b;
  logic [3:0] cnt_b;

  unidad_control_multiciclo #(.MAX_ESPERA(16), .CNT_W(32), .HAB_JAL(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .opcode(opcode_a), .mem_listo(mem_listo_a), .zero(zero_a),
    .estado(estado_a), .alu_op(alu_op_a), .alu_fuente(alu_fuente_a),
    .mem_lectura(mem_lectura_a), .mem_escritura(mem_escritura_a), .iord(iord_a),
    .ir_escritura(ir_escritura_a), .pc_escritura(pc_escritura_a), .pc_fuente(pc_fuente_a),
    .reg_escritura(reg_escritura_a), .mem_a_reg(mem_a_reg_a), .trampa(trampa_a),
    .causa_trampa(causa_a), .contador_instr(cnt_a)
  );

  unidad_control_multiciclo #(.MAX_ESPERA(4), .CNT_W(4), .HAB_JAL(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode_b), .mem_listo(mem_listo_b), .zero(zero_b),
    .estado(estado_b), .alu_op(alu_op_b), .alu_fuente(alu_fuente_b),
    .mem_lectura(mem_lectura_b), .mem_escritura(mem_escritura_b), .iord(iord_b),
    .ir_escritura(ir_escritura_b), .pc_escritura(pc_escritura_b), .pc_fuente(pc_fuente_b),
    .reg_escritura(reg_escritura_b), .mem_a_reg(mem_a_reg_b), .trampa(trampa_b),
    .causa_trampa(causa_b), .contador_instr(cnt_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {estado_a, alu_op_a, alu_fuente_a, mem_lectura_a, mem_escritura_a, iord_a,
                  ir_escritura_a, pc_escritura_a, pc_fuente_a, reg_escritura_a, mem_a_reg_a,
                  trampa_a, causa_a, cnt_a};
  assign obs_b = {estado_b, alu_op_b, alu_fuente_b, mem_lectura_b, mem_escritura_b, iord_b,
                  ir_escritura_b, pc_escritura_b, pc_fuente_b, reg_escritura_b, mem_a_reg_b,
                  trampa_b, causa_b, 28'd0, cnt_b};

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cur = 0;
  int unsigned cnt_m[2] = '{0, 0};
  int unsigned cnt_mask[2] = '{32'hFFFF_FFFF, 32'hF};
  int unsigned max_esp[2] = '{16, 4};
  bit          hab_jal[2] = '{1'b1, 1'b0};
  logic [6:0]  ops[6] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL};

  function automatic obs_t mk(input logic [2:0] s);
    obs_t e;
    e = '0;
    e.estado = s;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  task automatic drive(input logic r, input logic [6:0] op, input logic l, input logic z);
    if (cur == 0) begin
      rst_a = r; opcode_a = op; mem_listo_a = l; zero_a = z;
    end else begin
      rst_b = r; opcode_b = op; mem_listo_b = l; zero_b = z;
    end
  endtask

  // One clock of stimulus with its predicted outputs queued for the monitor
  task automatic step(input obs_t e, input string tag, input logic l, input logic z,
                      input logic [6:0] op);
    exp_t x;
    drive(1'b0, op, l, z);
    e.cnt  = cnt_m[cur];
    x.dut  = cur;
    x.o    = e;
    x.tag  = tag;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    cnt_m[cur] = (cnt_m[cur] + 1) & cnt_mask[cur];
  endtask

  task automatic do_reset();
    drive(1'b1, rop(), rb(), rb());
    @(posedge clk);
    #1;
    cnt_m[cur] = 0;
  endtask

  task automatic trap_hold(input logic c, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = mk(3'd5);
      e.trampa = 1'b1;
      e.causa  = c;
      step(e, "trap", rb(), rb(), rop());
    end
  endtask

  task automatic do_fetch(input int waits);
    obs_t e;
    for (int i = 0; i < waits; i++) begin
      e = mk(3'd0);
      e.mem_lectura = 1'b1;
      step(e, "fetch_wait", 1'b0, rb(), rop());
    end
    e = mk(3'd0);
    e.mem_lectura  = 1'b1;
    e.ir_escritura = 1'b1;
    e.pc_escritura = 1'b1;
    step(e, "fetch_done", 1'b1, rb(), rop());
  endtask

  task automatic do_wb(input logic lw);
    obs_t e;
    e = mk(3'd4);
    e.reg_escritura = 1'b1;
    e.mem_a_reg     = lw ? 2'b01 : 2'b00;
    step(e, "wb", rb(), rb(), rop());
    retire();
  endtask

  // Full instruction: fw/mw are memory wait cycles; mem_tout forces a MEM timeout
  task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic z,
                       input bit mem_tout);
    obs_t e;
    bit   legal;
    legal = (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
            (op == OP_BR) || ((op == OP_JAL) && hab_jal[cur]);
    do_fetch(fw);
    step(mk(3'd1), "decode", rb(), rb(), op);
    if (!legal) begin
      trap_hold(1'b0, 3);
      return;
    end
    e = mk(3'd2);
    if ((op == OP_R) || (op == OP_I)) begin
      e.alu_op     = 2'b10;
      e.alu_fuente = (op == OP_I);
      step(e, "exec_alu", rb(), rb(), rop());
      do_wb(1'b0);
    end else if ((op == OP_LW) || (op == OP_SW)) begin
      e.alu_fuente = 1'b1;
      step(e, "exec_addr", rb(), rb(), rop());
      e = mk(3'd3);
      e.iord          = 1'b1;
      e.alu_fuente    = 1'b1;
      e.mem_lectura   = (op == OP_LW);
      e.mem_escritura = (op == OP_SW);
      for (int i = 0; i < (mem_tout ? max_esp[cur] : mw); i++)
        step(e, "mem_wait", 1'b0, rb(), rop());
      if (mem_tout) begin
        trap_hold(1'b1, 4);
        return;
      end
      step(e, "mem_done", 1'b1, rb(), rop());
      if (op == OP_LW) do_wb(1'b1);
      else retire();
    end else if (op == OP_BR) begin
      e.alu_op       = 2'b01;
      e.pc_fuente    = 2'b01;
      e.pc_escritura = z;
      step(e, "exec_br", rb(), z, rop());
      retire();
    end else begin
      e.pc_fuente     = 2'b10;
      e.pc_escritura  = 1'b1;
      e.reg_escritura = 1'b1;
      e.mem_a_reg     = 2'b10;
      step(e, "exec_jal", rb(), rb(), rop());
      retire();
    end
  endtask

  task automatic fetch_timeout();
    obs_t e;
    for (int i = 0; i < max_esp[cur]; i++) begin
      e = mk(3'd0);
      e.mem_lectura = 1'b1;
      step(e, "fetch_tout", 1'b0, rb(), rop());
    end
    trap_hold(1'b1, 5);
  endtask

  task automatic random_instrs(input int n);
    logic [6:0] op;
    for (int i = 0; i < n; i++) begin
      op = ops[$urandom_range(0, hab_jal[cur] ? 5 : 4)];
      instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(), 1'b0);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction each cycle
  initial begin
    exp_t x;
    obs_t act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = (x.dut == 0) ? obs_a : obs_b;
        n_vec++;
        if (act !== x.o) begin
          n_err++;
          $display("FAIL %s dut%0d t=%0t: got %h expected %h", x.tag, x.dut, $time, act, x.o);
        end
      end
    end
  end

  initial begin
    // Configuration A: defaults
    cur = 0;
    @(posedge clk);
    #1;
    instr(OP_R, 0, 0, 1'b0, 1'b0);
    instr(OP_LW, 0, 3, 1'b0, 1'b0);
    instr(OP_BR, 0, 0, 1'b1, 1'b0);
    instr(OP_BR, 0, 0, 1'b0, 1'b0);
    instr(OP_JAL, 1, 0, 1'b0, 1'b0);
    instr(OP_SW, 2, 2, 1'b0, 1'b0);
    instr(OP_I, 15, 0, 1'b0, 1'b0);
    random_instrs(150);
    instr(7'b1111111, 0, 0, 1'b0, 1'b0);
    trap_hold(1'b0, 17);
    do_reset();
    instr(OP_R, 0, 0, 1'b0, 1'b0);
    fetch_timeout();
    do_reset();
    instr(OP_LW, 0, 0, 1'b0, 1'b1);
    do_reset();
    instr(OP_SW, 0, 15, 1'b0, 1'b0);
    random_instrs(10);
    drive(1'b1, 7'd0, 1'b0, 1'b0);

    // Configuration B: short timeout, 4-bit counter, JAL illegal
    cur = 1;
    random_instrs(20);
    instr(OP_LW, 3, 3, 1'b0, 1'b0);
    instr(OP_JAL, 0, 0, 1'b0, 1'b0);
    trap_hold(1'b1 ^ 1'b1, 5);
    do_reset();
    fetch_timeout();
    do_reset();
    instr(OP_SW, 0, 0, 1'b0, 1'b1);
    do_reset();
    instr(OP_BR, 0, 0, 1'b1, 1'b0);
    drive(1'b1, 7'd0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
